// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through L1D signature-based
// (SHiP-style) hit predictor training path.
//
// Contents:
//   SHIP_SIG_WIDTH - signature width; equals the predictor table index width
//   ship_meta_t    - per-line training metadata {valid, outcome, sig}
//   rrpv_e         - insertion RRPV encodings returned by the predictor
package wt_cache_pkg;

    localparam int unsigned SHIP_SIG_WIDTH = 14;

    typedef struct packed {
        logic                      valid;
        logic                      outcome;
        logic [SHIP_SIG_WIDTH-1:0] sig;
    } ship_meta_t;

    typedef enum logic [1:0] {
        IMM   = 2'd0,
        INTER = 2'd2,
        DIST  = 2'd3
    } rrpv_e;

endpackage

// File: rtl/wt_dcache_ship_meta_bank.sv
// Per-line SHiP metadata storage for every set/way of the L1D.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            clear every valid and outcome bit at the next edge
//   hit_set_i/way_i    hit port address
//   hit_valid_o        valid bit of the addressed hit line (combinational)
//   hit_sig_o          signature of the addressed hit line (combinational)
//   hit_we_i           set the outcome bit of the hit line
//   fill_set_i/way_i   fill port address
//   fill_rdata_o       victim metadata at the fill address (combinational)
//   fill_we_i          write fill_wdata_i to the fill line
//   fill_wdata_i       new metadata for the fill line
//
// The fill write is applied after the hit write, so on a same-line collision
// the freshly allocated line is never marked as reused.
module wt_dcache_ship_meta_bank
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumSets = 256,
    parameter int unsigned NumWays = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic [$clog2(NumSets)-1:0] hit_set_i,
    input  logic [$clog2(NumWays)-1:0] hit_way_i,
    output logic                       hit_valid_o,
    output logic [SHIP_SIG_WIDTH-1:0]  hit_sig_o,
    input  logic                       hit_we_i,
    input  logic [$clog2(NumSets)-1:0] fill_set_i,
    input  logic [$clog2(NumWays)-1:0] fill_way_i,
    output ship_meta_t                 fill_rdata_o,
    input  logic                       fill_we_i,
    input  ship_meta_t                 fill_wdata_i
);

    ship_meta_t meta_q [NumSets][NumWays];

    assign hit_valid_o  = meta_q[hit_set_i][hit_way_i].valid;
    assign hit_sig_o    = meta_q[hit_set_i][hit_way_i].sig;
    assign fill_rdata_o = meta_q[fill_set_i][fill_way_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < NumWays; w++) begin
                    meta_q[s][w] <= '0;
                end
            end
        end else if (flush_i) begin
            // Signatures are left in place; without valid they are never read.
            for (int s = 0; s < NumSets; s++) begin
                for (int w = 0; w < NumWays; w++) begin
                    meta_q[s][w].valid   <= 1'b0;
                    meta_q[s][w].outcome <= 1'b0;
                end
            end
        end else begin
            if (hit_we_i) begin
                meta_q[hit_set_i][hit_way_i].outcome <= 1'b1;
            end
            if (fill_we_i) begin
                meta_q[fill_set_i][fill_way_i] <= fill_wdata_i;
            end
        end
    end

endmodule

// File: rtl/wt_dcache_ship_trainer.sv
// Training-side front end of the L1D SHiP hit predictor. Tracks per-line
// signature/outcome metadata and turns cache hit, fill and eviction events
// into one-cycle registered training pulses for the predictor.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              invalidate all metadata; events this cycle ignored
//   hit_*_i              cache hit event (valid, set, way)
//   fill_*_i             line allocation event (valid, set, way, signature)
//   pred_result_i        predictor insertion result for the fill
//   pred_hit_o           train-up pulse, pred_hit_shct_o = reused signature
//   pred_miss_o          eviction pulse, pred_miss_shct_o / pred_outcome_o
//                        describe the victim
//   pred_shct_o          lookup signature (fill_sig_i, zero latency)
//   ins_rrpv_o           insertion RRPV (pred_result_i, zero latency)
//   hit_train_cnt_o      saturating count of pred_hit_o pulses
//   dead_evict_cnt_o     saturating count of evictions of never-reused lines
module wt_dcache_ship_trainer
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumSets  = 256,
    parameter int unsigned NumWays  = 8,
    parameter int unsigned SigWidth = SHIP_SIG_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       hit_valid_i,
    input  logic [$clog2(NumSets)-1:0] hit_set_i,
    input  logic [$clog2(NumWays)-1:0] hit_way_i,
    input  logic                       fill_valid_i,
    input  logic [$clog2(NumSets)-1:0] fill_set_i,
    input  logic [$clog2(NumWays)-1:0] fill_way_i,
    input  logic [SigWidth-1:0]        fill_sig_i,
    input  logic [1:0]                 pred_result_i,
    output logic                       pred_hit_o,
    output logic [SigWidth-1:0]        pred_hit_shct_o,
    output logic                       pred_miss_o,
    output logic                       pred_outcome_o,
    output logic [SigWidth-1:0]        pred_miss_shct_o,
    output logic [SigWidth-1:0]        pred_shct_o,
    output logic [1:0]                 ins_rrpv_o,
    output logic [31:0]                hit_train_cnt_o,
    output logic [31:0]                dead_evict_cnt_o
);

    logic                hit_line_valid;
    logic [SigWidth-1:0] hit_line_sig;
    ship_meta_t          victim_meta;
    ship_meta_t          fill_meta;
    logic                fill_fire;
    logic                same_line;
    logic                hit_fire;
    logic                evict_fire;
    logic [31:0]         hit_cnt_q;
    logic [31:0]         dead_cnt_q;

    assign pred_shct_o = fill_sig_i;
    assign ins_rrpv_o  = pred_result_i;

    assign fill_fire  = fill_valid_i & ~flush_i;
    assign same_line  = (hit_set_i == fill_set_i) && (hit_way_i == fill_way_i);
    // A hit colliding with a fill targets the line being replaced; drop it.
    assign hit_fire   = hit_valid_i & ~flush_i & hit_line_valid & ~(fill_fire & same_line);
    assign evict_fire = fill_fire & victim_meta.valid;

    assign fill_meta.valid   = 1'b1;
    assign fill_meta.outcome = 1'b0;
    assign fill_meta.sig     = fill_sig_i;

    wt_dcache_ship_meta_bank #(
        .NumSets (NumSets),
        .NumWays (NumWays)
    ) u_meta_bank (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .hit_set_i    (hit_set_i),
        .hit_way_i    (hit_way_i),
        .hit_valid_o  (hit_line_valid),
        .hit_sig_o    (hit_line_sig),
        .hit_we_i     (hit_fire),
        .fill_set_i   (fill_set_i),
        .fill_way_i   (fill_way_i),
        .fill_rdata_o (victim_meta),
        .fill_we_i    (fill_fire),
        .fill_wdata_i (fill_meta)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pred_hit_o       <= 1'b0;
            pred_hit_shct_o  <= '0;
            pred_miss_o      <= 1'b0;
            pred_outcome_o   <= 1'b0;
            pred_miss_shct_o <= '0;
            hit_cnt_q        <= '0;
            dead_cnt_q       <= '0;
        end else begin
            pred_hit_o  <= hit_fire;
            pred_miss_o <= evict_fire;
            if (hit_fire) begin
                pred_hit_shct_o <= hit_line_sig;
                if (hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
            end
            if (evict_fire) begin
                pred_miss_shct_o <= victim_meta.sig;
                pred_outcome_o   <= victim_meta.outcome;
                if (!victim_meta.outcome && (dead_cnt_q != 32'hFFFF_FFFF)) begin
                    dead_cnt_q <= dead_cnt_q + 32'd1;
                end
            end
        end
    end

    assign hit_train_cnt_o  = hit_cnt_q;
    assign dead_evict_cnt_o = dead_cnt_q;

endmodule

// File: tb/tb_wt_dcache_ship_trainer.sv
module tb_wt_dcache_ship_trainer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        hit_valid_i;
    logic [7:0]  hit_set_i;
    logic [2:0]  hit_way_i;
    logic        fill_valid_i;
    logic [7:0]  fill_set_i;
    logic [2:0]  fill_way_i;
    logic [13:0] fill_sig_i;
    logic [1:0]  pred_result_i;
    logic        pred_hit_o;
    logic [13:0] pred_hit_shct_o;
    logic        pred_miss_o;
    logic        pred_outcome_o;
    logic [13:0] pred_miss_shct_o;
    logic [13:0] pred_shct_o;
    logic [1:0]  ins_rrpv_o;
    logic [31:0] hit_train_cnt_o;
    logic [31:0] dead_evict_cnt_o;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    wt_dcache_ship_trainer dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .hit_valid_i      (hit_valid_i),
        .hit_set_i        (hit_set_i),
        .hit_way_i        (hit_way_i),
        .fill_valid_i     (fill_valid_i),
        .fill_set_i       (fill_set_i),
        .fill_way_i       (fill_way_i),
        .fill_sig_i       (fill_sig_i),
        .pred_result_i    (pred_result_i),
        .pred_hit_o       (pred_hit_o),
        .pred_hit_shct_o  (pred_hit_shct_o),
        .pred_miss_o      (pred_miss_o),
        .pred_outcome_o   (pred_outcome_o),
        .pred_miss_shct_o (pred_miss_shct_o),
        .pred_shct_o      (pred_shct_o),
        .ins_rrpv_o       (ins_rrpv_o),
        .hit_train_cnt_o  (hit_train_cnt_o),
        .dead_evict_cnt_o (dead_evict_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        flush_i      = 1'b0;
        hit_valid_i  = 1'b0;
        fill_valid_i = 1'b0;
    endtask

    task automatic set_hit(input logic [7:0] s, input logic [2:0] w);
        hit_valid_i = 1'b1;
        hit_set_i   = s;
        hit_way_i   = w;
    endtask

    task automatic set_fill(input logic [7:0] s, input logic [2:0] w, input logic [13:0] sig);
        fill_valid_i = 1'b1;
        fill_set_i   = s;
        fill_way_i   = w;
        fill_sig_i   = sig;
    endtask

    initial begin
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        hit_valid_i   = 1'b0;
        hit_set_i     = '0;
        hit_way_i     = '0;
        fill_valid_i  = 1'b0;
        fill_set_i    = '0;
        fill_way_i    = '0;
        fill_sig_i    = '0;
        pred_result_i = 2'd0;
        cyc();
        cyc();
        chk("rst_pred_hit", {31'd0, pred_hit_o}, 32'd0);
        chk("rst_pred_miss", {31'd0, pred_miss_o}, 32'd0);
        chk("rst_hit_shct", {18'd0, pred_hit_shct_o}, 32'd0);
        chk("rst_hit_cnt", hit_train_cnt_o, 32'd0);
        chk("rst_dead_cnt", dead_evict_cnt_o, 32'd0);
        rst_ni = 1'b1;
        cyc();

        // hit to an invalid line: nothing
        set_hit(8'd1, 3'd1);
        cyc();
        idle();
        chk("inv_hit_pulse", {31'd0, pred_hit_o}, 32'd0);
        chk("inv_hit_cnt", hit_train_cnt_o, 32'd0);

        // first fill, invalid victim; zero-latency lookup paths
        set_fill(8'd5, 3'd2, 14'h1ABC);
        pred_result_i = 2'd2;
        #1;
        chk("lookup_sig", {18'd0, pred_shct_o}, 32'h1ABC);
        chk("ins_rrpv_2", {30'd0, ins_rrpv_o}, 32'd2);
        pred_result_i = 2'd3;
        #1;
        chk("ins_rrpv_3", {30'd0, ins_rrpv_o}, 32'd3);
        cyc();
        idle();
        chk("fill_inv_miss", {31'd0, pred_miss_o}, 32'd0);

        // two hits
        set_hit(8'd5, 3'd2);
        cyc();
        chk("hit1_pulse", {31'd0, pred_hit_o}, 32'd1);
        chk("hit1_shct", {18'd0, pred_hit_shct_o}, 32'h1ABC);
        chk("hit1_cnt", hit_train_cnt_o, 32'd1);
        cyc();
        idle();
        chk("hit2_pulse", {31'd0, pred_hit_o}, 32'd1);
        chk("hit2_cnt", hit_train_cnt_o, 32'd2);
        cyc();
        chk("hit_pulse_end", {31'd0, pred_hit_o}, 32'd0);
        chk("hit_shct_hold", {18'd0, pred_hit_shct_o}, 32'h1ABC);

        // refill of a reused line
        set_fill(8'd5, 3'd2, 14'h0003);
        cyc();
        idle();
        chk("evict_live_pulse", {31'd0, pred_miss_o}, 32'd1);
        chk("evict_live_sig", {18'd0, pred_miss_shct_o}, 32'h1ABC);
        chk("evict_live_out", {31'd0, pred_outcome_o}, 32'd1);
        chk("evict_live_dead", dead_evict_cnt_o, 32'd0);
        cyc();
        chk("miss_pulse_end", {31'd0, pred_miss_o}, 32'd0);
        chk("miss_sig_hold", {18'd0, pred_miss_shct_o}, 32'h1ABC);

        // dead eviction
        set_fill(8'd5, 3'd2, 14'h0044);
        cyc();
        idle();
        chk("evict_dead_pulse", {31'd0, pred_miss_o}, 32'd1);
        chk("evict_dead_sig", {18'd0, pred_miss_shct_o}, 32'h0003);
        chk("evict_dead_out", {31'd0, pred_outcome_o}, 32'd0);
        chk("evict_dead_cnt", dead_evict_cnt_o, 32'd1);

        // same-line hit + fill: fill wins, stored outcome reported
        set_hit(8'd5, 3'd2);
        set_fill(8'd5, 3'd2, 14'h0055);
        cyc();
        fill_valid_i = 1'b0;
        chk("coll_hit_pulse", {31'd0, pred_hit_o}, 32'd0);
        chk("coll_miss_pulse", {31'd0, pred_miss_o}, 32'd1);
        chk("coll_miss_sig", {18'd0, pred_miss_shct_o}, 32'h0044);
        chk("coll_outcome", {31'd0, pred_outcome_o}, 32'd0);
        chk("coll_hit_cnt", hit_train_cnt_o, 32'd2);
        chk("coll_dead_cnt", dead_evict_cnt_o, 32'd2);
        // back-to-back hit sees the new signature
        cyc();
        idle();
        chk("b2b_hit_pulse", {31'd0, pred_hit_o}, 32'd1);
        chk("b2b_hit_shct", {18'd0, pred_hit_shct_o}, 32'h0055);
        chk("b2b_hit_cnt", hit_train_cnt_o, 32'd3);

        // hit and fill on different lines in the same cycle
        set_fill(8'd9, 3'd0, 14'h0099);
        cyc();
        idle();
        set_hit(8'd9, 3'd0);
        set_fill(8'd5, 3'd2, 14'h0066);
        cyc();
        idle();
        chk("dual_hit_pulse", {31'd0, pred_hit_o}, 32'd1);
        chk("dual_hit_shct", {18'd0, pred_hit_shct_o}, 32'h0099);
        chk("dual_miss_pulse", {31'd0, pred_miss_o}, 32'd1);
        chk("dual_miss_sig", {18'd0, pred_miss_shct_o}, 32'h0055);
        chk("dual_outcome", {31'd0, pred_outcome_o}, 32'd1);
        chk("dual_hit_cnt", hit_train_cnt_o, 32'd4);
        chk("dual_dead_cnt", dead_evict_cnt_o, 32'd2);

        // flush with concurrent hit
        flush_i = 1'b1;
        set_hit(8'd9, 3'd0);
        cyc();
        flush_i = 1'b0;
        chk("flush_hit_pulse", {31'd0, pred_hit_o}, 32'd0);
        cyc();
        hit_valid_i = 1'b0;
        chk("post_flush_hit", {31'd0, pred_hit_o}, 32'd0);
        chk("flush_keep_hcnt", hit_train_cnt_o, 32'd4);
        chk("flush_keep_dcnt", dead_evict_cnt_o, 32'd2);
        set_fill(8'd5, 3'd2, 14'h0011);
        cyc();
        idle();
        chk("post_flush_fill", {31'd0, pred_miss_o}, 32'd0);

        // hit counter saturation
        set_fill(8'd9, 3'd0, 14'h0012);
        cyc();
        idle();
        force dut.hit_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.hit_cnt_q;
        set_hit(8'd9, 3'd0);
        cyc();
        chk("sat_cnt_1", hit_train_cnt_o, 32'hFFFF_FFFF);
        cyc();
        chk("sat_cnt_2", hit_train_cnt_o, 32'hFFFF_FFFF);
        chk("sat_pulse", {31'd0, pred_hit_o}, 32'd1);

        // asynchronous reset mid-pulse
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_pulse", {31'd0, pred_hit_o}, 32'd0);
        chk("arst_hit_cnt", hit_train_cnt_o, 32'd0);
        chk("arst_shct", {18'd0, pred_hit_shct_o}, 32'd0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wt_dcache_ship_trainer.md
Name: wt_dcache_ship_trainer

Overview:
Training-side front end for the write-through L1D signature hit-counter predictor. Holds per-line metadata (signature, valid, outcome) for every set/way. Converts cache hit, fill and eviction events into registered training pulses for the predictor's hit and miss ports. Forwards the incoming fill signature to the predictor lookup, and returns the predictor's insertion hint to the replacement logic.

Parameters:
NumSets, 256, number of L1D sets
NumWays, 8, associativity
SigWidth, 14, signature width; must match the predictor table index

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous invalidate of all metadata
hit_valid_i  in  1  load/store hit this cycle
hit_set_i  in  log2(NumSets)  hit set index
hit_way_i  in  log2(NumWays)  hit way
fill_valid_i  in  1  line fill (allocation) this cycle
fill_set_i  in  log2(NumSets)  fill set index
fill_way_i  in  log2(NumWays)  victim/fill way
fill_sig_i  in  SigWidth  signature of the allocating access
pred_result_i  in  2  predictor insertion result (0 immediate, 2 intermediate, 3 distant)
pred_hit_o  out  1  train-up pulse
pred_hit_shct_o  out  SigWidth  signature to increment
pred_miss_o  out  1  eviction pulse
pred_outcome_o  out  1  outcome bit of evicted line
pred_miss_shct_o  out  SigWidth  evicted signature
pred_shct_o  out  SigWidth  lookup signature; combinational copy of fill_sig_i
ins_rrpv_o  out  2  insertion RRPV for the fill; combinational copy of pred_result_i
hit_train_cnt_o  out  32  saturating count of pred_hit_o pulses
dead_evict_cnt_o  out  32  saturating count of evictions with outcome 0

Behaviour:
- Reset state: all valid/outcome/sig bits are 0. All registered outputs are 0; both counters are 0.
- Metadata per line is {valid, outcome, sig[SigWidth-1:0]}.
- Hit, when hit_valid_i is set and the addressed line is valid:
  - next cycle, pred_hit_o=1 and pred_hit_shct_o=stored sig;
  - line outcome is set to 1;
  - a hit to an invalid line emits nothing and changes nothing.
- Fill, when fill_valid_i is set:
  - if the victim is valid: next cycle, pred_miss_o=1, pred_miss_shct_o=victim sig, pred_outcome_o=victim outcome;
  - if the victim is invalid: no miss pulse;
  - the line is then written {1, 0, fill_sig_i}.
- Latency: training outputs are registered, one cycle after the event. They are a pulse for exactly one cycle, and the sig/outcome fields hold their values while idle. pred_shct_o and ins_rrpv_o have zero latency.
- Simultaneous hit and fill, different lines: both are processed; pred_hit_o and pred_miss_o may assert in the same cycle.
- Simultaneous hit and fill, same set/way: fill wins.
  - The hit is dropped: no pred_hit_o pulse, and the hit counter does not increment.
  - The victim's outcome reported is its stored value. The same-cycle hit does not set it.
- Back-to-back fill then hit to the same line in the next cycle: the hit sees the new metadata, so pred_hit_shct_o is the new sig.
- Flush:
  - flush_i clears every valid and outcome bit at the next edge;
  - hit and fill events in the flush cycle are ignored, with no pulses the following cycle;
  - flush does not clear the counters.
- Counters increment with each emitted pulse and saturate at 32'hFFFF_FFFF.
- Reset mid-operation: asynchronous assert forces all state and outputs to their reset values immediately. Any in-flight pulse is lost.

Decomposition:
- wt_cache_pkg gains:
  - ship_meta_t struct {valid, outcome, sig};
  - SHIP_SIG_WIDTH=14;
  - RRPV enum constants IMM=0, INTER=2, DIST=3.
- One sub-module, wt_dcache_ship_meta_bank: per-set metadata storage with one read/write port for hit and one for fill. The fill write takes priority on a same-way collision.

Test Plan:
- Reset then fill set 5 way 2 with sig 0x1ABC (victim invalid) -> no pred_miss_o; ins_rrpv_o equals pred_result_i in the same cycle.
- Hit set 5 way 2 twice -> two pred_hit_o pulses with pred_hit_shct_o=0x1ABC; hit_train_cnt_o=2.
- Refill set 5 way 2 with sig 0x0003 -> pred_miss_o=1, pred_miss_shct_o=0x1ABC, pred_outcome_o=1; dead_evict_cnt_o unchanged.
- Fill a line, evict it with no hits -> pred_outcome_o=0, dead_evict_cnt_o increments.
- Same-cycle hit and fill to the same set/way -> only pred_miss_o pulses. Same cycle to different ways -> both pulse in one cycle.
- flush_i with a concurrent hit -> no pulse. A subsequent hit to the previously valid line -> no pulse. Counters are retained. Force a counter to 32'hFFFF_FFFE plus two events -> it stays at 32'hFFFF_FFFF.
